cbm2_keyboard: RTL

- Converts PS/2 key events from hps_io (`ps2_key`) into the CBM-II 16-column × 6-row keyboard matrix.
- Sits directly upstream of the keyboard TPI inside the main core: the TPI drives column select, this block returns the row lines.
- Holds the pressed state of every matrix key, plus a latched Shift Lock.

---
 rtl/cbm2_keyboard.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cbm2_keyboard.sv
// Translates hps_io PS/2 key events into the CBM-II 16x6 keyboard matrix read by the keyboard TPI.
// Three-stage event pipeline (detect, lookup, apply) plus a registered active-low row read.
module cbm2_keyboard #(
    parameter bit SHIFTLOCK_TOGGLE = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        pause,
    input  logic [15:0] col_sel,
    output logic [5:0]  row_out,
    output logic        key_event,
    output logic        shift_lock
);
    typedef struct packed {
        logic       valid;
        logic       caps;
        logic [3:0] col;
        logic [2:0] row;
    } key_pos_t;

    function automatic key_pos_t pos(input int unsigned col, input int unsigned row);
        pos = '{valid: 1'b1, caps: 1'b0, col: 4'(col), row: 3'(row)};
    endfunction

    // Set-2 scancode (bit 8 = E0 prefix) to matrix position; Caps Lock owns col 1, row 4.
    function automatic key_pos_t lookup(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h076: lookup = pos(1, 0);
            9'h005: lookup = pos(2, 0);
            9'h006: lookup = pos(3, 0);
            9'h004: lookup = pos(4, 0);
            9'h00C: lookup = pos(5, 0);
            9'h003: lookup = pos(6, 0);
            9'h00B: lookup = pos(7, 0);
            9'h083: lookup = pos(8, 0);
            9'h00A: lookup = pos(9, 0);
            9'h001: lookup = pos(10, 0);
            9'h009: lookup = pos(11, 0);
            9'h016: lookup = pos(1, 1);
            9'h01E: lookup = pos(2, 1);
            9'h026: lookup = pos(3, 1);
            9'h025: lookup = pos(4, 1);
            9'h02E: lookup = pos(5, 1);
            9'h036: lookup = pos(6, 1);
            9'h03D: lookup = pos(7, 1);
            9'h03E: lookup = pos(8, 1);
            9'h046: lookup = pos(9, 1);
            9'h045: lookup = pos(10, 1);
            9'h04E: lookup = pos(11, 1);
            9'h055: lookup = pos(12, 1);
            9'h066: lookup = pos(13, 1);
            9'h175: lookup = pos(14, 1);
            9'h00D: lookup = pos(1, 2);
            9'h01C: lookup = pos(2, 2);
            9'h01B: lookup = pos(3, 2);
            9'h023: lookup = pos(4, 2);
            9'h02B: lookup = pos(5, 2);
            9'h034: lookup = pos(6, 2);
            9'h033: lookup = pos(7, 2);
            9'h03B: lookup = pos(8, 2);
            9'h042: lookup = pos(9, 2);
            9'h04B: lookup = pos(10, 2);
            9'h04C: lookup = pos(11, 2);
            9'h052: lookup = pos(12, 2);
            9'h05A: lookup = pos(13, 2);
            9'h172: lookup = pos(14, 2);
            9'h014: lookup = pos(1, 3);
            9'h015: lookup = pos(2, 3);
            9'h01D: lookup = pos(3, 3);
            9'h024: lookup = pos(4, 3);
            9'h02D: lookup = pos(5, 3);
            9'h02C: lookup = pos(6, 3);
            9'h035: lookup = pos(7, 3);
            9'h03C: lookup = pos(8, 3);
            9'h043: lookup = pos(9, 3);
            9'h044: lookup = pos(10, 3);
            9'h04D: lookup = pos(11, 3);
            9'h054: lookup = pos(12, 3);
            9'h05B: lookup = pos(13, 3);
            9'h16B: lookup = pos(14, 3);
            9'h012: lookup = pos(0, 4);
            9'h059: lookup = pos(0, 4);
            9'h058: lookup = '{valid: 1'b1, caps: 1'b1, col: 4'd1, row: 3'd4};
            9'h01A: lookup = pos(2, 4);
            9'h022: lookup = pos(3, 4);
            9'h021: lookup = pos(4, 4);
            9'h02A: lookup = pos(5, 4);
            9'h032: lookup = pos(6, 4);
            9'h031: lookup = pos(7, 4);
            9'h03A: lookup = pos(8, 4);
            9'h041: lookup = pos(9, 4);
            9'h049: lookup = pos(10, 4);
            9'h04A: lookup = pos(11, 4);
            9'h05D: lookup = pos(12, 4);
            9'h174: lookup = pos(14, 4);
            9'h011: lookup = pos(1, 5);
            9'h029: lookup = pos(2, 5);
            9'h170: lookup = pos(12, 5);
            9'h171: lookup = pos(13, 5);
            9'h16C: lookup = pos(14, 5);
            default: lookup = '0;
        endcase
    endfunction

    logic       old_toggle;
    logic       new_event;
    logic       s0_valid;
    logic       s0_pressed;
    logic       s0_ext;
    logic [7:0] s0_code;
    key_pos_t   s1_pos;
    logic       s1_pressed;
    logic [5:0] mat [16];
    logic [5:0] rows_hit;

    assign new_event  = (ps2_key[10] != old_toggle) && !pause;
    assign shift_lock = mat[1][4];

    // Stage 0: a toggle flip is the event; while paused it stays pending against old_toggle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_toggle <= ps2_key[10];
            s0_valid   <= 1'b0;
            s0_pressed <= 1'b0;
            s0_ext     <= 1'b0;
            s0_code    <= '0;
        end else begin
            s0_valid <= new_event;
            if (new_event) begin
                old_toggle                      <= ps2_key[10];
                {s0_pressed, s0_ext, s0_code} <= ps2_key[9:0];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_pos     <= '0;
            s1_pressed <= 1'b0;
        end else begin
            s1_pos     <= s0_valid ? lookup(s0_ext, s0_code) : '0;
            s1_pressed <= s0_pressed;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: the matrix is 96 discrete flops rather than a RAM, so it is cleared on reset like any other state.
            for (int c = 0; c < 16; c++) mat[c] <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (s1_pos.valid) begin
                if (s1_pos.caps && SHIFTLOCK_TOGGLE) begin
                    if (s1_pressed) begin
                        mat[1][4] <= !mat[1][4];
                        key_event <= 1'b1;
                    end
                end else if (mat[s1_pos.col][s1_pos.row] != s1_pressed) begin
                    mat[s1_pos.col][s1_pos.row] <= s1_pressed;
                    key_event                   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: combinational block uses blocking assignments with the default set first, so no latch is inferred.
        rows_hit = '0;
        for (int c = 0; c < 16; c++) begin
            if (!col_sel[c]) rows_hit = rows_hit | mat[c];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) row_out <= 6'h3F;
        else       row_out <= ~rows_hit;
    end
endmodule
